// File: rtl/bus_datapath_if.sv
// Control-strobe and shared-bus bundle between the ALU
// instruction FSM (master) and the datapath (slave).
interface bus_datapath_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) ();
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] param2num;
  logic             immediate_out;
  logic             ALUin1;
  logic             ALUin2;
  logic             ALU_outlach;
  logic             ALU_outEN;
  logic             G0_in;
  logic             G1_in;
  logic             G2_in;
  logic             G3_in;
  logic             G0_out;
  logic             G1_out;
  logic             G2_out;
  logic             G3_out;
  logic [WIDTH-1:0] bus;
  logic             bus_idle;
  logic             bus_conflict;

  modport master (
    output alu_op, param2num, immediate_out,
    output ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    output G0_in, G1_in, G2_in, G3_in,
    output G0_out, G1_out, G2_out, G3_out,
    input  bus, bus_idle, bus_conflict
  );

  modport slave (
    input  alu_op, param2num, immediate_out,
    input  ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    input  G0_in, G1_in, G2_in, G3_in,
    input  G0_out, G1_out, G2_out, G3_out,
    output bus, bus_idle, bus_conflict
  );
endinterface

// File: rtl/bus_datapath.sv
// Shared-bus datapath: G0-G3, ALU operand/result latches,
// strobe-driven bus transfers and sticky conflict monitor.
module bus_datapath #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  bus_datapath_if.slave    ctl,
  output logic [WIDTH-1:0] g0,
  output logic [WIDTH-1:0] g1,
  output logic [WIDTH-1:0] g2,
  output logic [WIDTH-1:0] g3,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  logic [1:0]       rsync;
  logic             srst_n;
  logic [5:0]       drv;
  logic [3:0]       gin;
  logic [2:0]       ndrv;
  logic             clash;
  logic [WIDTH-1:0] bus_v;
  logic [WIDTH:0]   alu_out;
  logic [WIDTH-1:0] g_q [4];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             carry_q;
  logic             conf_q;

  // Assert immediately, release two edges after rst rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsync <= 2'b00;
    else      rsync <= {rsync[0], 1'b1};
  end

  assign srst_n = rsync[1];

  assign drv = {ctl.ALU_outEN, ctl.immediate_out,
                ctl.G3_out, ctl.G2_out,
                ctl.G1_out, ctl.G0_out};
  assign gin = {ctl.G3_in, ctl.G2_in,
                ctl.G1_in, ctl.G0_in};

  always_comb begin
    ndrv = '0;
    for (int i = 0; i < 6; i++)
      ndrv = ndrv + {2'b00, drv[i]};
  end

  assign clash = srst_n && (ndrv > 3'd1);

  always_comb begin
    bus_v = '0;
    if (srst_n && ndrv == 3'd1) begin
      unique case (1'b1)
        drv[0]: bus_v = g_q[0];
        drv[1]: bus_v = g_q[1];
        drv[2]: bus_v = g_q[2];
        drv[3]: bus_v = g_q[3];
        drv[4]: bus_v = ctl.param2num;
        drv[5]: bus_v = res_q;
      endcase
    end
  end

  assign ctl.bus          = bus_v;
  assign ctl.bus_idle     = !srst_n || (ndrv == 3'd0);
  assign ctl.bus_conflict = conf_q;

  function automatic logic [WIDTH:0] alu_f(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [OPW-1:0]   op
  );
    logic [WIDTH:0] r;
    case (op)
      OPW'(0): r = {1'b0, b};
      OPW'(1): r = {1'b0, a} + {1'b0, b};
      OPW'(2): r = {a < b, a - b};
      OPW'(3): r = {1'b0, a & b};
      OPW'(4): r = {1'b0, a | b};
      OPW'(5): r = {1'b0, a ^ b};
      OPW'(6): r = {1'b0, ~a};
      OPW'(7): r = {a[WIDTH-1], a << 1};
      OPW'(8): r = {a[0], a >> 1};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign alu_out = alu_f(a_q, b_q, ctl.alu_op);

  // A conflicting cycle changes nothing except the sticky flag
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < 4; i++) g_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      conf_q  <= 1'b0;
    end else if (clash) begin
      conf_q <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (gin[i]) g_q[i] <= bus_v;
      if (ctl.ALUin1) a_q <= bus_v;
      if (ctl.ALUin2) b_q <= bus_v;
      if (ctl.ALU_outlach) begin
        res_q   <= alu_out[WIDTH-1:0];
        carry_q <= alu_out[WIDTH];
        zero_q  <= (alu_out[WIDTH-1:0] == '0);
      end
    end
  end

  assign g0     = g_q[0];
  assign g1     = g_q[1];
  assign g2     = g_q[2];
  assign g3     = g_q[3];
  assign result = res_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Bench for bus_datapath: ALU vector table, directed
// corner sequences and a randomized cycle-level model.
module tb_bus_datapath;

  logic        clk;
  logic        rst;
  logic [15:0] g0, g1, g2, g3, result;
  logic        zero, carry;
  int          n_chk;
  int          n_fail;

  bus_datapath_if #(.WIDTH(16), .OPW(4)) bif ();

  bus_datapath #(.WIDTH(16), .OPW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl    (bif),
    .g0     (g0),
    .g1     (g1),
    .g2     (g2),
    .g3     (g3),
    .result (result),
    .zero   (zero),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tv [13];

  int mg [4];
  int ma, mb, mres;
  bit mz, mc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr();
    bif.alu_op        = '0;
    bif.param2num     = '0;
    bif.immediate_out = 0;
    bif.ALUin1        = 0;
    bif.ALUin2        = 0;
    bif.ALU_outlach   = 0;
    bif.ALU_outEN     = 0;
    bif.G0_in  = 0; bif.G1_in  = 0;
    bif.G2_in  = 0; bif.G3_in  = 0;
    bif.G0_out = 0; bif.G1_out = 0;
    bif.G2_out = 0; bif.G3_out = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  // Reference ALU from the opcode table in integer arithmetic
  function automatic logic [16:0] ref_alu(
    input int a, input int b, input int op);
    int r;
    bit c;
    c = 0;
    case (op)
      0: r = b;
      1: begin r = a + b; c = (r > 65535); r = r % 65536; end
      2: begin c = (a < b); r = (a - b + 65536) % 65536; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 65535 - a;
      7: begin c = (a >= 32768); r = (a * 2) % 65536; end
      8: begin c = (a % 2 == 1); r = a / 2; end
      default: r = a;
    endcase
    return {c, r[15:0]};
  endfunction

  task automatic alu_run(input vec_t v, input int k);
    bif.param2num = v.a; bif.immediate_out = 1;
    bif.ALUin1 = 1;
    tick();
    bif.param2num = v.b; bif.immediate_out = 1;
    bif.ALUin2 = 1;
    tick();
    bif.alu_op = v.op; bif.ALU_outlach = 1;
    tick();
    chk($sformatf("vec%0d_result", k), result, v.res);
    chk($sformatf("vec%0d_carry", k), carry, v.c);
    chk($sformatf("vec%0d_zero", k), zero, v.z);
    bif.ALU_outEN = 1;
    #1;
    chk($sformatf("vec%0d_bus", k), bif.bus, v.res);
    tick();
  endtask

  initial begin
    logic [16:0] ar;
    int          d, p, op, eb;
    bit          gi [4];
    bit          a1, a2, la;

    n_chk  = 0;
    n_fail = 0;

    tv[0]  = '{4'h2, 16'h0000, 16'h0001, 16'hFFFF, 1, 0};
    tv[1]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1, 1};
    tv[2]  = '{4'h3, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0};
    tv[3]  = '{4'h7, 16'h8001, 16'h0000, 16'h0002, 1, 0};
    tv[4]  = '{4'h0, 16'h5555, 16'h00AA, 16'h00AA, 0, 0};
    tv[5]  = '{4'h8, 16'h0003, 16'h0000, 16'h0001, 1, 0};
    tv[6]  = '{4'h5, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1};
    tv[7]  = '{4'h2, 16'h0005, 16'h0007, 16'hFFFE, 1, 0};
    tv[8]  = '{4'h4, 16'hF0F0, 16'h0F01, 16'hFFF1, 0, 0};
    tv[9]  = '{4'h1, 16'h1234, 16'h1111, 16'h2345, 0, 0};
    tv[10] = '{4'h6, 16'h00FF, 16'h0000, 16'hFF00, 0, 0};
    tv[11] = '{4'h7, 16'h4000, 16'h0000, 16'h8000, 0, 0};
    tv[12] = '{4'hC, 16'hABCD, 16'h0001, 16'hABCD, 0, 0};

    // Reset with a driver active: bus must stay quiet
    clr();
    rst = 1'b0;
    bif.param2num = 16'hABCD;
    bif.immediate_out = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", bif.bus, 16'h0);
    chk("rst_idle", bif.bus_idle, 1'b1);
    chk("rst_g0", g0, 16'h0);
    chk("rst_g1", g1, 16'h0);
    chk("rst_g2", g2, 16'h0);
    chk("rst_g3", g3, 16'h0);
    chk("rst_result", result, 16'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_carry", carry, 1'b0);
    chk("rst_conflict", bif.bus_conflict, 1'b0);
    clr();
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_after_rst", bif.bus_idle, 1'b1);

    // Load and add
    bif.param2num = 16'h0002; bif.immediate_out = 1;
    bif.G0_in = 1;
    #1;
    chk("imm_bus_comb", bif.bus, 16'h0002);
    chk("imm_not_idle", bif.bus_idle, 1'b0);
    tick();
    chk("la_g0", g0, 16'h0002);
    bif.G0_out = 1; bif.ALUin1 = 1;
    tick();
    bif.param2num = 16'h0003; bif.immediate_out = 1;
    bif.ALUin2 = 1;
    tick();
    bif.alu_op = 4'h1; bif.ALU_outlach = 1;
    tick();
    bif.ALU_outEN = 1; bif.G1_in = 1;
    tick();
    chk("la_g1", g1, 16'h0005);
    chk("la_zero", zero, 1'b0);
    chk("la_carry", carry, 1'b0);

    // Same register in and out, multiple sinks
    bif.G1_out = 1; bif.G1_in = 1; bif.G2_in = 1;
    tick();
    chk("self_g1", g1, 16'h0005);
    chk("multi_g2", g2, 16'h0005);

    for (int k = 0; k < 13; k++) alu_run(tv[k], k);

    // Operand latch and outlach in the same cycle
    bif.param2num = 16'h0004; bif.immediate_out = 1;
    bif.ALUin1 = 1;
    tick();
    bif.param2num = 16'h0001; bif.immediate_out = 1;
    bif.ALUin2 = 1;
    tick();
    bif.param2num = 16'h0010; bif.immediate_out = 1;
    bif.ALUin1 = 1;
    bif.alu_op = 4'h1; bif.ALU_outlach = 1;
    tick();
    chk("order_result", result, 16'h0005);
    bif.ALU_outEN = 1;
    bif.alu_op = 4'hF; bif.ALU_outlach = 1;
    #1;
    chk("outen_old_bus", bif.bus, 16'h0005);
    tick();
    chk("order_newA", result, 16'h0010);

    // Randomized sequences against the cycle model
    do_reset();
    for (int i = 0; i < 4; i++) mg[i] = 0;
    ma = 0; mb = 0; mres = 0; mz = 1; mc = 0;
    for (int t = 0; t < 300; t++) begin
      d  = $urandom_range(0, 7);
      p  = $urandom_range(0, 65535);
      op = $urandom_range(0, 15);
      for (int i = 0; i < 4; i++)
        gi[i] = ($urandom_range(0, 2) == 0);
      a1 = ($urandom_range(0, 2) == 0);
      a2 = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 3) == 0);
      clr();
      bif.param2num = p[15:0];
      bif.alu_op = op[3:0];
      case (d)
        0: begin bif.G0_out = 1; eb = mg[0]; end
        1: begin bif.G1_out = 1; eb = mg[1]; end
        2: begin bif.G2_out = 1; eb = mg[2]; end
        3: begin bif.G3_out = 1; eb = mg[3]; end
        4: begin bif.immediate_out = 1; eb = p; end
        5: begin bif.ALU_outEN = 1; eb = mres; end
        default: eb = 0;
      endcase
      bif.G0_in = gi[0]; bif.G1_in = gi[1];
      bif.G2_in = gi[2]; bif.G3_in = gi[3];
      bif.ALUin1 = a1; bif.ALUin2 = a2;
      bif.ALU_outlach = la;
      #1;
      chk("rnd_bus", bif.bus, eb[15:0]);
      chk("rnd_idle", bif.bus_idle, d > 5);
      if (la) begin
        ar = ref_alu(ma, mb, op);
        mres = ar[15:0];
        mc = ar[16];
        mz = (mres == 0);
      end
      for (int i = 0; i < 4; i++) if (gi[i]) mg[i] = eb;
      if (a1) ma = eb;
      if (a2) mb = eb;
      @(posedge clk);
      #1;
      chk("rnd_g0", g0, mg[0][15:0]);
      chk("rnd_g1", g1, mg[1][15:0]);
      chk("rnd_g2", g2, mg[2][15:0]);
      chk("rnd_g3", g3, mg[3][15:0]);
      chk("rnd_result", result, mres[15:0]);
      chk("rnd_zero", zero, mz);
      chk("rnd_carry", carry, mc);
      chk("rnd_noconf", bif.bus_conflict, 1'b0);
    end
    clr();

    // Two drivers: bus zero, sinks inhibited, flag sticky
    bif.G0_out = 1;
    bif.param2num = 16'h7777; bif.immediate_out = 1;
    bif.G2_in = 1; bif.ALUin1 = 1;
    bif.alu_op = 4'h6; bif.ALU_outlach = 1;
    #1;
    chk("conf_bus", bif.bus, 16'h0);
    chk("conf_not_idle", bif.bus_idle, 1'b0);
    tick();
    chk("conf_g2", g2, mg[2][15:0]);
    chk("conf_result", result, mres[15:0]);
    chk("conf_flag", bif.bus_conflict, 1'b1);
    repeat (3) tick();
    chk("conf_sticky", bif.bus_conflict, 1'b1);

    // Async reset between edges while a latch is pending
    bif.param2num = 16'h1234; bif.immediate_out = 1;
    bif.G3_in = 1;
    tick();
    chk("pre_g3", g3, 16'h1234);
    bif.param2num = 16'h5678; bif.immediate_out = 1;
    bif.G3_in = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_g3", g3, 16'h0);
    chk("arst_result", result, 16'h0);
    chk("arst_zero", zero, 1'b1);
    chk("arst_conf", bif.bus_conflict, 1'b0);
    chk("arst_bus", bif.bus, 16'h0);
    chk("arst_idle", bif.bus_idle, 1'b1);
    @(posedge clk);
    #1;
    chk("arst_nocap", g3, 16'h0);
    clr();
    #2;
    rst = 1'b1;
    repeat (4) tick();
    bif.param2num = 16'h1234; bif.immediate_out = 1;
    bif.G3_in = 1;
    tick();
    chk("resume_g3", g3, 16'h1234);
    chk("resume_conf", bif.bus_conflict, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
